uart_ram_loader: RTL and testbench

UART_RAM_LOADER -- requirements
Module: uart_ram_loader

---
 rtl/uart_ram_loader.sv | 216 +++++++++++++++++++++
 tb/tb_uart_ram_loader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ram_loader.sv
// Receives 8N1 UART bytes and loads framed payloads (A5, len, data..., xor) into a byte RAM.
// Receiver and frame FSMs each use one always_comb (_d) and one always_ff (_q).
//
// state   | meaning
// RX_IDLE | line idle, waiting for a falling edge
// RX_START| counting to start-bit midpoint, re-checking low
// RX_DATA | sampling 8 data bits, LSB first
// RX_STOP | sampling stop bit
// F_IDLE  | waiting for 0xA5 header
// F_LEN   | waiting for length byte
// F_DATA  | writing payload bytes to RAM
// F_CSUM  | comparing checksum byte with running XOR
module uart_ram_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DEPTH        = 65
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       load_active,
    output logic       done,
    output logic       err
);
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [8:0]       DEPTH_MAX = 9'(DEPTH);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {F_IDLE, F_LEN, F_DATA, F_CSUM} f_state_t;

    logic rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t rx_state_q, rx_state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shift_q, shift_d, byte_q, byte_d;
    logic byte_valid_q, byte_valid_d, frame_err_q, frame_err_d;

    always_comb begin
        rx_state_d   = rx_state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        byte_d       = byte_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    cnt_d      = HALF_LAST;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (cnt_q == '0) begin
                    if (!rx_sync_q) begin
                        cnt_d      = BIT_LAST;
                        idx_d      = 3'd0;
                        rx_state_d = RX_DATA;
                    end else begin
                        rx_state_d = RX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    cnt_d   = BIT_LAST;
                    if (idx_q == 3'd7) rx_state_d = RX_STOP;
                    else               idx_d      = idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == '0) begin
                    if (rx_sync_q) begin
                        byte_valid_d = 1'b1;
                        byte_d       = shift_q;
                    end else begin
                        frame_err_d  = 1'b1;
                    end
                    rx_state_d = RX_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= RX_IDLE;
            cnt_q        <= '0;
            idx_q        <= 3'd0;
            shift_q      <= 8'd0;
            byte_q       <= 8'd0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_meta_q    <= rx;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            rx_state_q   <= rx_state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    f_state_t f_state_q, f_state_d;
    logic [7:0] len_q, len_d, addr_q, addr_d, csum_q, csum_d;
    logic [7:0] wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
    logic wr_en_q, wr_en_d, load_active_q, load_active_d, done_q, done_d, err_q, err_d;

    always_comb begin
        f_state_d     = f_state_q;
        len_d         = len_q;
        addr_d        = addr_q;
        csum_d        = csum_q;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        load_active_d = load_active_q;
        err_d         = err_q;
        wr_en_d       = 1'b0;
        done_d        = 1'b0;
        // A framing error aborts any frame in progress; stray ones while idle are ignored.
        if (frame_err_q && f_state_q != F_IDLE) begin
            err_d         = 1'b1;
            load_active_d = 1'b0;
            f_state_d     = F_IDLE;
        end else if (byte_valid_q) begin
            case (f_state_q)
                F_IDLE: begin
                    if (byte_q == 8'hA5) begin
                        load_active_d = 1'b1;
                        err_d         = 1'b0;
                        csum_d        = 8'd0;
                        f_state_d     = F_LEN;
                    end
                end
                F_LEN: begin
                    if (byte_q != 8'd0 && {1'b0, byte_q} <= DEPTH_MAX) begin
                        len_d     = byte_q;
                        addr_d    = 8'd0;
                        f_state_d = F_DATA;
                    end else begin
                        err_d         = 1'b1;
                        load_active_d = 1'b0;
                        f_state_d     = F_IDLE;
                    end
                end
                F_DATA: begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = byte_q;
                    csum_d    = csum_q ^ byte_q;
                    if (addr_q == len_q - 8'd1) f_state_d = F_CSUM;
                    else                        addr_d    = addr_q + 8'd1;
                end
                F_CSUM: begin
                    if (byte_q == csum_q) done_d = 1'b1;
                    else                  err_d  = 1'b1;
                    load_active_d = 1'b0;
                    f_state_d     = F_IDLE;
                end
                default: f_state_d = F_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            f_state_q     <= F_IDLE;
            len_q         <= 8'd0;
            addr_q        <= 8'd0;
            csum_q        <= 8'd0;
            wr_addr_q     <= 8'd0;
            wr_data_q     <= 8'd0;
            wr_en_q       <= 1'b0;
            load_active_q <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            f_state_q     <= f_state_d;
            len_q         <= len_d;
            addr_q        <= addr_d;
            csum_q        <= csum_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            wr_en_q       <= wr_en_d;
            load_active_q <= load_active_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign load_active = load_active_q;
    assign done        = done_q;
    assign err         = err_q;
endmodule

// File: tb/tb_uart_ram_loader.sv
// Self-checking bench for uart_ram_loader: RAM writes are scoreboarded against a queue of expected
// (addr, data) pairs pushed as frames are sent; flags are checked inline per scenario.
module tb_uart_ram_loader;
    localparam int CLKS = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       wr_en, load_active, done, err;
    logic [7:0] wr_addr, wr_data;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_w;
    logic       wr_en_prev = 1'b0;
    logic [7:0] addr_prev = 8'd0, data_prev = 8'd0;

    uart_ram_loader #(.CLKS_PER_BIT(CLKS), .DEPTH(65)) dut (
        .clk(clk), .reset(reset), .rx(rx),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .load_active(load_active), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Write monitor: pops the scoreboard on every strobe and checks hold/pulse-width behaviour.
    always @(negedge clk) begin
        if (!reset) begin
            if (wr_en) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_write: got addr=%h data=%h, required no write", wr_addr, wr_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if ({wr_addr, wr_data} !== exp_w) begin
                        n_err++;
                        $display("FAIL write_value: got addr=%h data=%h, required addr=%h data=%h",
                                 wr_addr, wr_data, exp_w[15:8], exp_w[7:0]);
                    end
                end
                n_cmp++;
                if (wr_en_prev !== 1'b0) begin
                    n_err++;
                    $display("FAIL wr_en_width: got wr_en high on consecutive cycles, required 1-cycle pulse");
                end
            end else begin
                n_cmp++;
                if (wr_addr !== addr_prev || wr_data !== data_prev) begin
                    n_err++;
                    $display("FAIL hold: got addr=%h data=%h, required addr=%h data=%h",
                             wr_addr, wr_data, addr_prev, data_prev);
                end
            end
            if (done) done_cnt++;
        end
        wr_en_prev = wr_en;
        addr_prev  = wr_addr;
        data_prev  = wr_data;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic good_stop);
        rx = 1'b0;
        wait_cycles(CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cycles(CLKS);
        end
        rx = good_stop;
        wait_cycles(CLKS);
        rx = 1'b1;
        wait_cycles(2);
    endtask

    task automatic check_flags(input string name, input int exp_done, input logic exp_err, input logic exp_la);
        n_cmp++;
        if (done_cnt !== exp_done) begin
            n_err++;
            $display("FAIL %s_done: got %0d pulses, required %0d", name, done_cnt, exp_done);
        end
        n_cmp++;
        if (err !== exp_err) begin
            n_err++;
            $display("FAIL %s_err: got %b, required %b", name, err, exp_err);
        end
        n_cmp++;
        if (load_active !== exp_la) begin
            n_err++;
            $display("FAIL %s_load_active: got %b, required %b", name, load_active, exp_la);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_writes: got %0d expected writes missing, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wait_cycles(4);
        n_cmp++;
        if ({wr_en, wr_addr, wr_data, load_active, done, err} !== 20'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b%h%h%b%b%b, required all zero",
                     wr_en, wr_addr, wr_data, load_active, done, err);
        end
        reset = 1'b0;
        wait_cycles(4);
    endtask

    task automatic test_basic();
        exp_q.push_back(16'h0011);
        exp_q.push_back(16'h0122);
        exp_q.push_back(16'h0233);
        send_byte(8'hA5, 1'b1);
        n_cmp++;
        if (load_active !== 1'b1) begin
            n_err++;
            $display("FAIL basic_la_header: got %b, required 1", load_active);
        end
        send_byte(8'h03, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        n_cmp++;
        if (load_active !== 1'b1) begin
            n_err++;
            $display("FAIL basic_la_before_csum: got %b, required 1", load_active);
        end
        send_byte(8'h00, 1'b1);
        wait_cycles(4);
        check_flags("basic", 1, 1'b0, 1'b0);
    endtask

    task automatic test_bad_csum();
        int d0 = done_cnt;
        exp_q.push_back(16'h000F);
        exp_q.push_back(16'h01F0);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h0F, 1'b1);
        send_byte(8'hF0, 1'b1);
        send_byte(8'h00, 1'b1);
        wait_cycles(4);
        check_flags("bad_csum", d0, 1'b1, 1'b0);
    endtask

    task automatic test_bad_len();
        int d0 = done_cnt;
        send_byte(8'hA5, 1'b1);
        n_cmp++;
        if (err !== 1'b0) begin
            n_err++;
            $display("FAIL len_err_cleared: got %b, required 0", err);
        end
        send_byte(8'h00, 1'b1);
        check_flags("len_zero", d0, 1'b1, 1'b0);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h42, 1'b1);
        check_flags("len_over", d0, 1'b1, 1'b0);
        exp_q.push_back(16'h0077);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h77, 1'b1);
        send_byte(8'h77, 1'b1);
        wait_cycles(4);
        check_flags("after_len", d0 + 1, 1'b0, 1'b0);
    endtask

    task automatic test_max_len();
        int d0 = done_cnt;
        logic [7:0] x = 8'd0;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h41, 1'b1);
        for (int i = 0; i <= 8'h40; i++) begin
            exp_q.push_back({8'(i), 8'(i)});
            x = x ^ 8'(i);
            send_byte(8'(i), 1'b1);
        end
        send_byte(x, 1'b1);
        wait_cycles(4);
        check_flags("max_len", d0 + 1, 1'b0, 1'b0);
        n_cmp++;
        if (wr_addr !== 8'h40 || wr_data !== 8'h40) begin
            n_err++;
            $display("FAIL max_len_last: got addr=%h data=%h, required addr=40 data=40", wr_addr, wr_data);
        end
    endtask

    task automatic test_frame_err();
        int d0 = done_cnt;
        exp_q.push_back(16'h00A5);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h5A, 1'b0);
        wait_cycles(4 * CLKS);
        check_flags("frame_err", d0, 1'b1, 1'b0);
    endtask

    task automatic test_glitch_reset();
        int d0 = done_cnt;
        logic [7:0] b = 8'h33;
        exp_q.push_back(16'h0011);
        exp_q.push_back(16'h0122);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        rx = 1'b0;
        wait_cycles(CLKS / 4);
        rx = 1'b1;
        wait_cycles(3 * CLKS);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        rx = 1'b0;
        wait_cycles(CLKS);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            wait_cycles(CLKS);
        end
        rx = b[4];
        wait_cycles(CLKS / 2);
        reset = 1'b1;
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(1);
        n_cmp++;
        if ({wr_en, wr_addr, wr_data, load_active, done, err} !== 20'd0) begin
            n_err++;
            $display("FAIL midreset_outputs: got %b%h%h%b%b%b, required all zero",
                     wr_en, wr_addr, wr_data, load_active, done, err);
        end
        wait_cycles(CLKS / 2 - 4);
        for (int i = 5; i < 8; i++) begin
            rx = b[i];
            wait_cycles(CLKS);
        end
        rx = 1'b1;
        wait_cycles(4 * CLKS);
        check_flags("glitch_reset", d0, 1'b0, 1'b0);
        n_cmp++;
        if (wr_addr !== 8'd0 || wr_data !== 8'd0) begin
            n_err++;
            $display("FAIL glitch_reset_bus: got addr=%h data=%h, required 00 00", wr_addr, wr_data);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_csum();
        test_bad_len();
        test_max_len();
        test_frame_err();
        test_glitch_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
